// File: rtl/controle_acesso.sv
// controle_acesso: access sequencer between the keypad PIN-packet source and
// the password verifier. A rising edge on pin_status_in sends one evaluation
// strobe to the verifier, then the block waits for a single verdict. The
// verdict either opens the door for a timed window, counts a failure (an
// escalating lockout starts after MAX_TENT consecutive failures), or hands
// control to setup mode on a master PIN.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   tick             one-cycle timebase pulse (1 Hz in the system)
//   pin_status_in    PIN packet status bit; a rising edge submits a new PIN
//   pin_strobe_out   one-cycle pulse: verifier must evaluate the PIN now
//   senha_fail       verdict pulse: PIN rejected
//   senha_padrao     verdict pulse: user PIN accepted
//   senha_master     verdict pulse: master PIN accepted
//   setup_done       setup module finished
//   tranca_aberta    door unlock drive
//   bloqueado        lockout active
//   setup_req        one-cycle pulse: enter setup
//   erro_timeout     one-cycle pulse: verifier gave no verdict in time
//   tentativas       consecutive failure count
//   tempo_restante   ticks left in the unlock window or lockout, else 0
//
// Handshake: there is no ready path. pin_strobe_out is a fire-and-forget
// request; exactly one of the verdict pulses is expected back while waiting,
// and any pulse arriving in another state is dropped.
module controle_acesso #(
  parameter int unsigned MAX_TENT     = 5,
  parameter int unsigned BLOQ_BASE    = 30,
  parameter int unsigned BLOQ_MAX     = 240,
  parameter int unsigned ABERTO_T     = 5,
  parameter int unsigned RESP_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pin_status_in,
  output logic       pin_strobe_out,
  input  logic       senha_fail,
  input  logic       senha_padrao,
  input  logic       senha_master,
  input  logic       setup_done,
  output logic       tranca_aberta,
  output logic       bloqueado,
  output logic       setup_req,
  output logic       erro_timeout,
  output logic [2:0] tentativas,
  output logic [7:0] tempo_restante
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    AGUARDA  = 3'd1,
    ABERTO   = 3'd2,
    BLOQUEIO = 3'd3,
    SETUP    = 3'd4
  } estado_t;

  estado_t    state, state_d;
  logic       prev;
  logic [7:0] dur, dur_d;
  logic [7:0] cnt, cnt_d;

  logic       strobe_d, tranca_d, bloq_d, setup_req_d, erro_d;
  logic [2:0] tent_d;
  logic [7:0] tempo_d;

  logic       pin_edge;
  logic [3:0] tent_inc;
  logic [8:0] dur2;
  logic [7:0] dur_next;

  assign pin_edge = pin_status_in & ~prev;
  assign tent_inc = {1'b0, tentativas} + 4'd1;

  // Next lockout length: doubled in 9 bits so 128..255 cannot wrap, then
  // clamped to BLOQ_MAX.
  assign dur2     = {dur, 1'b0};
  assign dur_next = (dur2 > 9'(BLOQ_MAX)) ? 8'(BLOQ_MAX) : dur2[7:0];

  always_comb begin
    state_d     = state;
    dur_d       = dur;
    cnt_d       = cnt;
    strobe_d    = 1'b0;
    setup_req_d = 1'b0;
    erro_d      = 1'b0;
    tranca_d    = tranca_aberta;
    bloq_d      = bloqueado;
    tent_d      = tentativas;
    tempo_d     = tempo_restante;

    unique case (state)
      OCIOSO: begin
        if (pin_edge) begin
          strobe_d = 1'b1;
          cnt_d    = 8'(RESP_TIMEOUT);
          state_d  = AGUARDA;
        end
      end

      AGUARDA: begin
        if (senha_master) begin
          tent_d      = 3'd0;
          dur_d       = 8'(BLOQ_BASE);
          setup_req_d = 1'b1;
          state_d     = SETUP;
        end else if (senha_padrao) begin
          tent_d   = 3'd0;
          dur_d    = 8'(BLOQ_BASE);
          tempo_d  = 8'(ABERTO_T);
          tranca_d = 1'b1;
          state_d  = ABERTO;
        end else if (senha_fail) begin
          if (tent_inc < 4'(MAX_TENT)) begin
            tent_d  = tent_inc[2:0];
            state_d = OCIOSO;
          end else begin
            tent_d  = 3'(MAX_TENT);
            bloq_d  = 1'b1;
            tempo_d = dur;
            state_d = BLOQUEIO;
          end
        end else if (cnt <= 8'd1) begin
          cnt_d   = 8'd0;
          erro_d  = 1'b1;
          state_d = OCIOSO;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end

      // Ticks are only honoured once the state is entered, so a tick in the
      // entry cycle never shortens the window.
      ABERTO: begin
        if (tick) begin
          if (tempo_restante <= 8'd1) begin
            tempo_d  = 8'd0;
            tranca_d = 1'b0;
            state_d  = OCIOSO;
          end else begin
            tempo_d = tempo_restante - 8'd1;
          end
        end
      end

      BLOQUEIO: begin
        if (tick) begin
          if (tempo_restante <= 8'd1) begin
            tempo_d = 8'd0;
            bloq_d  = 1'b0;
            tent_d  = 3'd0;
            dur_d   = dur_next;
            state_d = OCIOSO;
          end else begin
            tempo_d = tempo_restante - 8'd1;
          end
        end
      end

      SETUP: begin
        if (setup_done) state_d = OCIOSO;
      end

      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= OCIOSO;
      prev           <= 1'b0;
      dur            <= 8'(BLOQ_BASE);
      cnt            <= 8'd0;
      pin_strobe_out <= 1'b0;
      tranca_aberta  <= 1'b0;
      bloqueado      <= 1'b0;
      setup_req      <= 1'b0;
      erro_timeout   <= 1'b0;
      tentativas     <= 3'd0;
      tempo_restante <= 8'd0;
    end else begin
      state          <= state_d;
      prev           <= pin_status_in;
      dur            <= dur_d;
      cnt            <= cnt_d;
      pin_strobe_out <= strobe_d;
      tranca_aberta  <= tranca_d;
      bloqueado      <= bloq_d;
      setup_req      <= setup_req_d;
      erro_timeout   <= erro_d;
      tentativas     <= tent_d;
      tempo_restante <= tempo_d;
    end
  end

endmodule

// File: tb/tb_controle_acesso.sv
// Testbench for controle_acesso: a table of per-cycle vectors for the basic
// flows, then hand-written sequences for hold/timeout, escalating lockouts
// and reset during a lockout.
module tb_controle_acesso;

  localparam int MAX_TENT = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, pin_status_in, senha_fail, senha_padrao, senha_master, setup_done;
  logic       pin_strobe_out, tranca_aberta, bloqueado, setup_req, erro_timeout;
  logic [2:0] tentativas;
  logic [7:0] tempo_restante;

  int n_checks = 0;
  int n_fail   = 0;

  controle_acesso dut (
    .clk            (clk),
    .rst            (rst),
    .tick           (tick),
    .pin_status_in  (pin_status_in),
    .pin_strobe_out (pin_strobe_out),
    .senha_fail     (senha_fail),
    .senha_padrao   (senha_padrao),
    .senha_master   (senha_master),
    .setup_done     (setup_done),
    .tranca_aberta  (tranca_aberta),
    .bloqueado      (bloqueado),
    .setup_req      (setup_req),
    .erro_timeout   (erro_timeout),
    .tentativas     (tentativas),
    .tempo_restante (tempo_restante)
  );

  // clock / reset
  always #5 clk = ~clk;

  // packed view of all outputs: {strobe, tranca, bloq, setup_req, erro, tent[2:0], tempo[7:0]}
  function automatic logic [15:0] outs();
    return {pin_strobe_out, tranca_aberta, bloqueado, setup_req, erro_timeout,
            tentativas, tempo_restante};
  endfunction

  function automatic logic [15:0] mk(input logic s, input logic t, input logic b,
                                     input logic r, input logic e,
                                     input logic [2:0] tn, input logic [7:0] tm);
    return {s, t, b, r, e, tn, tm};
  endfunction

  typedef struct {
    logic        pin;
    logic        tk;
    logic        fail;
    logic        pad;
    logic        mas;
    logic        sdone;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] exp_q[$];

  task automatic add(input logic pin, input logic tk, input logic fail, input logic pad,
                     input logic mas, input logic sdone, input logic [15:0] exp);
    vec_t v;
    v.pin = pin; v.tk = tk; v.fail = fail; v.pad = pad; v.mas = mas; v.sdone = sdone;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change at negedge, outputs are read at the next negedge
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    tick = 0; pin_status_in = 0; senha_fail = 0; senha_padrao = 0;
    senha_master = 0; setup_done = 0;
  endtask

  task automatic submit(input string name);
    pin_status_in = 1; cyc();
    chk({name, " strobe"}, int'(pin_status_in & pin_strobe_out), 1);
    pin_status_in = 0;
  endtask

  task automatic fail_round(input int k);
    submit($sformatf("fail_round%0d", k));
    senha_fail = 1; cyc(); senha_fail = 0;
  endtask

  task automatic ticks(input int n);
    tick = 1; repeat (n) cyc(); tick = 0;
  endtask

  task automatic padrao_round();
    submit("padrao");
    senha_padrao = 1; cyc(); senha_padrao = 0;
    chk("padrao open", int'(outs()), int'(mk(0, 1, 0, 0, 0, 0, 5)));
    ticks(5);
    chk("padrao closed", int'(outs()), 0);
  endtask

  task automatic lockout_enter(input int dur);
    for (int k = 1; k <= MAX_TENT; k++) begin
      fail_round(k);
      if (k < MAX_TENT)
        chk($sformatf("tent after fail %0d", k), int'(outs()), int'(mk(0, 0, 0, 0, 0, 3'(k), 0)));
      else
        chk($sformatf("lockout entry dur %0d", dur), int'(outs()),
            int'(mk(0, 0, 1, 0, 0, 3'(MAX_TENT), 8'(dur))));
    end
  endtask

  task automatic lockout(input int dur);
    lockout_enter(dur);
    pin_status_in = 1; cyc();
    chk("edge in lockout strobe", int'(pin_strobe_out), 0);
    pin_status_in = 0;
    ticks(dur - 1);
    chk($sformatf("lockout %0d last tick", dur), int'(outs()),
        int'(mk(0, 0, 1, 0, 0, 3'(MAX_TENT), 1)));
    ticks(1);
    chk($sformatf("lockout %0d end", dur), int'(outs()), 0);
  endtask

  initial begin
    int n;
    rst = 1;
    idle_inputs();
    repeat (2) cyc();
    chk("reset outputs", int'(outs()), 0);
    rst = 0;
    cyc();
    chk("idle after reset", int'(outs()), 0);

    //  pin tk fail pad mas sd   expected outputs
    add(1, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 1, 0, 0, mk(0, 1, 0, 0, 0, 0, 5));
    add(0, 1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 4));
    add(0, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 4));
    add(0, 1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 3));
    add(0, 1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 2));
    add(0, 1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 1));
    add(0, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0));
    add(0, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0));
    add(1, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 1, 0));
    add(0, 0, 1, 0, 1, 0, mk(0, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
    add(0, 1, 1, 1, 0, 0, mk(0, 1, 0, 0, 0, 0, 5));
    add(0, 1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 4));
    add(0, 1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 3));
    add(0, 1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 2));
    add(0, 1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 1));
    add(0, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      pin_status_in = vecs[i].pin; tick = vecs[i].tk; senha_fail = vecs[i].fail;
      senha_padrao = vecs[i].pad; senha_master = vecs[i].mas; setup_done = vecs[i].sdone;
      exp_q.push_back(vecs[i].exp);
      cyc();
      chk($sformatf("vec[%0d]", i), int'(outs()), int'(exp_q.pop_front()));
    end
    idle_inputs();
    cyc();

    // held level gives a single strobe; then the verifier stays silent
    fail_round(1);
    pin_status_in = 1; cyc();
    chk("hold first strobe", int'(pin_strobe_out), 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("hold no strobe %0d", i), int'(pin_strobe_out), 0);
    end
    pin_status_in = 0;
    n = 10;
    while (!erro_timeout && n < 40) begin
      cyc();
      n++;
    end
    chk("timeout latency", n, 16);
    chk("timeout outputs", int'(outs()), int'(mk(0, 0, 0, 0, 1, 1, 0)));
    cyc();
    chk("timeout pulse width", int'(erro_timeout), 0);

    // tentativas back to 0 through an accepted PIN, then escalate
    padrao_round();
    lockout(30);
    lockout(60);
    padrao_round();
    lockout(30);
    lockout(60);
    lockout(120);
    lockout(240);
    lockout_enter(240);
    ticks(223);
    chk("tempo before reset", int'(tempo_restante), 17);

    // asynchronous reset mid-cycle during a lockout
    #2 rst = 1;
    #1 chk("async reset outputs", int'(outs()), 0);
    cyc();
    rst = 0;
    cyc();
    chk("after reset outputs", int'(outs()), 0);
    lockout_enter(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
